// File: rtl/sequenciador_nota_pkg.sv
// Shared constants for the note sequencer: FSM state codes and the rest-note code.
package sequenciador_nota_pkg;

  localparam int LARGURA_ESTADO = 2;

  localparam logic [LARGURA_ESTADO-1:0] OCIOSO = 2'd0;
  localparam logic [LARGURA_ESTADO-1:0] TOCA   = 2'd1;
  localparam logic [LARGURA_ESTADO-1:0] PAUSA  = 2'd2;
  localparam logic [LARGURA_ESTADO-1:0] FIM    = 2'd3;

  localparam int NOTA_SILENCIO = 0;

  // True when the code drives sound, i.e. anything other than the rest code.
  function automatic logic nota_audivel(input logic [31:0] codigo);
    return codigo != 32'(NOTA_SILENCIO);
  endfunction

endpackage

// File: rtl/contador_ciclos.sv
// Cycle counter shared by the TOCA and PAUSA phases; the limit is selected at runtime.
module contador_ciclos #(
  parameter int LARGURA = 25
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               zera,
  input  logic               conta,
  input  logic [LARGURA-1:0] limite,
  output logic [LARGURA-1:0] valor,
  output logic               fim
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      valor <= '0;
    end else if (zera) begin
      valor <= '0;
    end else if (conta) begin
      valor <= valor + LARGURA'(1);
    end
  end

  assign fim = (valor == limite - LARGURA'(1));

endmodule

// File: rtl/sequenciador_nota.sv
// Note-playback timer: plays a latched note code for a fixed on-time, inserts a gap,
// then pulses muda_nota. Optional macro SEQ_NOTA_DURACAO_VAR_EN adds a per-note
// duration multiplier (duracao+1) implemented with a repeat counter.
module sequenciador_nota
  import sequenciador_nota_pkg::*;
#(
  parameter int CICLOS_NOTA  = 25000000,
  parameter int CICLOS_PAUSA = 5000000,
  parameter int LARGURA_NOTA = 4,
  parameter int LARGURA_CONT = 25
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      iniciar,
  input  logic [LARGURA_NOTA-1:0]   nota,
`ifdef SEQ_NOTA_DURACAO_VAR_EN
  input  logic [1:0]                duracao,
`endif
  input  logic                      abortar,
  output logic                      ocupado,
  output logic [LARGURA_NOTA-1:0]   nota_arduino,
  output logic                      ativa_arduino,
  output logic                      muda_nota,
  output logic [LARGURA_ESTADO-1:0] db_estado
);

  localparam bit TEM_PAUSA = (CICLOS_PAUSA > 0);

  logic [LARGURA_ESTADO-1:0] estado;
  logic [LARGURA_ESTADO-1:0] prox_estado;
  logic [LARGURA_NOTA-1:0]   nota_reg;
  logic [LARGURA_CONT-1:0]   limite;
  logic [LARGURA_CONT-1:0]   valor_cont;
  logic                      zera;
  logic                      conta;
  logic                      fim_cont;
  logic                      aceita;
  logic                      ultima_repeticao;

  assign aceita = (estado == OCIOSO) && iniciar && !abortar;

`ifdef SEQ_NOTA_DURACAO_VAR_EN
  logic [1:0] duracao_reg;
  logic [1:0] repeticao;
  logic       repete;

  assign ultima_repeticao = (repeticao == duracao_reg);
  assign repete = (estado == TOCA) && !abortar && fim_cont && !ultima_repeticao;

  // The on-time is the base count replayed duracao+1 times, avoiding a multiplier.
  always_ff @(posedge clock) begin
    if (reset) begin
      duracao_reg <= 2'd0;
      repeticao   <= 2'd0;
    end else if (aceita) begin
      duracao_reg <= duracao;
      repeticao   <= 2'd0;
    end else if (repete) begin
      repeticao   <= repeticao + 2'd1;
    end
  end
`else
  assign ultima_repeticao = 1'b1;
`endif

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    prox_estado = estado;
    zera        = 1'b1;
    conta       = 1'b0;
    case (estado)
      OCIOSO: begin
        if (iniciar && !abortar) prox_estado = TOCA;
      end
      TOCA: begin
        if (abortar) begin
          prox_estado = OCIOSO;
        end else if (fim_cont) begin
          if (ultima_repeticao) prox_estado = TEM_PAUSA ? PAUSA : FIM;
        end else begin
          zera  = 1'b0;
          conta = 1'b1;
        end
      end
      PAUSA: begin
        if (abortar) begin
          prox_estado = OCIOSO;
        end else if (fim_cont) begin
          prox_estado = FIM;
        end else begin
          zera  = 1'b0;
          conta = 1'b1;
        end
      end
      FIM:     prox_estado = OCIOSO;
      default: prox_estado = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado   <= OCIOSO;
      nota_reg <= '0;
    end else begin
      estado <= prox_estado;
      if (aceita) nota_reg <= nota;
    end
  end

  assign limite = (estado == PAUSA) ? LARGURA_CONT'(CICLOS_PAUSA)
                                    : LARGURA_CONT'(CICLOS_NOTA);

  contador_ciclos #(
    .LARGURA (LARGURA_CONT)
  ) u_contador (
    .clock  (clock),
    .reset  (reset),
    .zera   (zera),
    .conta  (conta),
    .limite (limite),
    .valor  (valor_cont),
    .fim    (fim_cont)
  );

  // Moore outputs: decoded from the registered state and latched note only.
  assign ocupado       = (estado != OCIOSO);
  assign nota_arduino  = (estado == TOCA) ? nota_reg : '0;
  assign ativa_arduino = (estado == TOCA) && nota_audivel(32'(nota_reg));
  assign muda_nota     = (estado == FIM);
  assign db_estado     = estado;

endmodule

// File: tb/tb_sequenciador_nota.sv
// Self-checking bench for sequenciador_nota: two instances (gap=2 and gap=0) against
// a cycle-arithmetic model, plus hand-computed literal expectations.
module tb_sequenciador_nota;

  localparam int CN = 4;
  localparam int LN = 4;
  localparam int LC = 8;

  logic clock = 1'b0;
  logic reset, iniciar, abortar;
  logic [LN-1:0] nota;
`ifdef SEQ_NOTA_DURACAO_VAR_EN
  logic [1:0] duracao;
`endif

  logic          ocup_a, ativa_a, muda_a, ocup_b, ativa_b, muda_b;
  logic [LN-1:0] nota_a, nota_b;
  logic [1:0]    est_a, est_b;

  always #5 clock = ~clock;

  sequenciador_nota #(.CICLOS_NOTA(CN), .CICLOS_PAUSA(2), .LARGURA_NOTA(LN), .LARGURA_CONT(LC)) u_dut_a (
    .clock(clock), .reset(reset), .iniciar(iniciar), .nota(nota),
`ifdef SEQ_NOTA_DURACAO_VAR_EN
    .duracao(duracao),
`endif
    .abortar(abortar), .ocupado(ocup_a), .nota_arduino(nota_a),
    .ativa_arduino(ativa_a), .muda_nota(muda_a), .db_estado(est_a));

  sequenciador_nota #(.CICLOS_NOTA(CN), .CICLOS_PAUSA(0), .LARGURA_NOTA(LN), .LARGURA_CONT(LC)) u_dut_b (
    .clock(clock), .reset(reset), .iniciar(iniciar), .nota(nota),
`ifdef SEQ_NOTA_DURACAO_VAR_EN
    .duracao(duracao),
`endif
    .abortar(abortar), .ocupado(ocup_b), .nota_arduino(nota_b),
    .ativa_arduino(ativa_b), .muda_nota(muda_b), .db_estado(est_b));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Model: a note is "active" from its accept cycle; everything else follows from
  // elapsed cycles t versus the on-time and gap lengths.
  typedef struct {
    bit act;
    int start;
    int nota;
    int on_c;
    int pau;
  } mdl_t;

  mdl_t m [2];
  int   pau_of [2] = '{2, 0};

  // Packed expected output vector: {ocupado, ativa, muda, estado[1:0], nota[3:0]}
  function automatic logic [31:0] esperado(input mdl_t md, input int c);
    int t;
    if (!md.act) return 32'd0;
    t = c - md.start;
    if (t <= md.on_c)
      return {23'd0, 1'b1, (md.nota != 0), 1'b0, 2'd1, 4'(md.nota)};
    else if (t <= md.on_c + md.pau)
      return {23'd0, 1'b1, 1'b0, 1'b0, 2'd2, 4'd0};
    else
      return {23'd0, 1'b1, 1'b0, 1'b1, 2'd3, 4'd0};
  endfunction

  always @(posedge clock) begin
    int dur;
`ifdef SEQ_NOTA_DURACAO_VAR_EN
    dur = int'(duracao);
`else
    dur = 0;
`endif
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m[k].act = 1'b0;
      end else if (m[k].act) begin
        if (cyc - m[k].start == m[k].on_c + m[k].pau + 1) m[k].act = 1'b0;
        else if (abortar) m[k].act = 1'b0;
      end else if (iniciar && !abortar) begin
        m[k].act   = 1'b1;
        m[k].start = cyc;
        m[k].nota  = int'(nota);
        m[k].on_c  = CN * (dur + 1);
        m[k].pau   = pau_of[k];
      end
    end
    cyc++;
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("model_a", {23'd0, ocup_a, ativa_a, muda_a, est_a, nota_a}, esperado(m[0], cyc));
      check("model_b", {23'd0, ocup_b, ativa_b, muda_b, est_b, nota_b}, esperado(m[1], cyc));
    end
  end

  task automatic go(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) m[k] = '{act: 1'b0, start: 0, nota: 0, on_c: 0, pau: 0};
    reset = 1'b1; iniciar = 1'b0; abortar = 1'b0; nota = '0;
`ifdef SEQ_NOTA_DURACAO_VAR_EN
    duracao = 2'd0;
`endif
    go(2);
    reset = 1'b0;
    chk_en = 1'b1;
    check("reset_ocupado", 32'(ocup_a), 0);
    check("reset_estado",  32'(est_a), 0);
    go(2);

    // Basic note: nota=5 accepted at cycle 0
    iniciar = 1'b1; nota = 4'd5;
    go(1); iniciar = 1'b0; nota = '0;
    check("basic_nota_c1",  32'(nota_a), 5);
    check("basic_ativa_c1", 32'(ativa_a), 1);
    go(3);
    check("basic_nota_c4",  32'(nota_a), 5);
    go(1);
    check("basic_nota_c5",  32'(nota_a), 0);
    check("basic_ocup_c5",  32'(ocup_a), 1);
    check("basic_b_muda_c5", 32'(muda_b), 1);
    go(1);
    check("basic_muda_c6",  32'(muda_a), 0);
    go(1);
    check("basic_muda_c7",  32'(muda_a), 1);
    go(1);
    check("basic_ocup_c8",  32'(ocup_a), 0);
    go(2);

    // Rest note
    iniciar = 1'b1; nota = 4'd0;
    go(1); iniciar = 1'b0;
    check("rest_ativa_c1", 32'(ativa_a), 0);
    check("rest_ocup_c1",  32'(ocup_a), 1);
    go(6);
    check("rest_muda_c7",  32'(muda_a), 1);
    go(3);

    // Abort on cycle 3
    iniciar = 1'b1; nota = 4'd9;
    go(1); iniciar = 1'b0;
    go(2); abortar = 1'b1;
    go(1); abortar = 1'b0;
    check("abort_ocup_c4",  32'(ocup_a), 0);
    check("abort_nota_c4",  32'(nota_a), 0);
    go(8);

    // Simultaneous abortar and iniciar in OCIOSO
    iniciar = 1'b1; abortar = 1'b1; nota = 4'd4;
    go(1);
    check("simul_ocup", 32'(ocup_a), 0);
    iniciar = 1'b0; abortar = 1'b0;
    go(2);

    // Mid-note reset on cycle 2, restart on cycle 5
    iniciar = 1'b1; nota = 4'd3;
    go(1); iniciar = 1'b0;
    go(1); reset = 1'b1;
    go(1); reset = 1'b0;
    check("reset_mid_outs", {23'd0, ocup_a, ativa_a, muda_a, est_a, nota_a}, 0);
    go(2); iniciar = 1'b1; nota = 4'd6;
    go(1); iniciar = 1'b0;
    check("reset_restart_nota_c6", 32'(nota_a), 6);
    go(6);
    check("reset_restart_muda_c12", 32'(muda_a), 1);
    go(3);

    // Held iniciar: back-to-back notes with one idle cycle between them
    iniciar = 1'b1; nota = 4'd2;
    go(7);
    check("hold_muda_c7", 32'(muda_a), 1);
    go(1);
    check("hold_idle_c8", 32'(ocup_a), 0);
    go(1);
    check("hold_nota_c9", 32'(nota_a), 2);
    go(10);
    iniciar = 1'b0;
    go(20);

    // No-gap instance; with the duration option, duracao=2 triples the on-time
`ifdef SEQ_NOTA_DURACAO_VAR_EN
    duracao = 2'd2;
`endif
    iniciar = 1'b1; nota = 4'd7;
    go(1); iniciar = 1'b0;
`ifdef SEQ_NOTA_DURACAO_VAR_EN
    duracao = 2'd0;
    check("dur_b_nota_c1", 32'(nota_b), 7);
    go(11);
    check("dur_b_nota_c12", 32'(nota_b), 7);
    go(1);
    check("dur_b_muda_c13", 32'(muda_b), 1);
`else
    check("nogap_b_nota_c1", 32'(nota_b), 7);
    go(3);
    check("nogap_b_nota_c4", 32'(nota_b), 7);
    go(1);
    check("nogap_b_muda_c5", 32'(muda_b), 1);
`endif
    go(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
